hilo_ctrl: RTL and testbench

//  Sequencer and HI/LO register owner sitting between the CPU control unit and the

---
 rtl/hilo_ctrl_if.sv | 43 ++++
 rtl/hilo_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_ctrl_if.sv
// hilo_ctrl_if: CPU control requests, multiply/divide unit handshake and HI/LO
// observation signals around hilo_ctrl. master = hilo_ctrl, slave = its environment.
interface hilo_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_mult;
  logic             op_div;
  logic             mult_start;
  logic             div_start;
  logic             mult_done;
  logic [WIDTH-1:0] mult_hi;
  logic [WIDTH-1:0] mult_lo;
  logic             div_done;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic             div_zero;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             mf_req;
  logic             err_clr;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             err_timeout;
  logic             err_div0;

  modport master (
    input  op_mult, op_div, mult_done, mult_hi, mult_lo,
    input  div_done, div_hi, div_lo, div_zero,
    input  mthi, mtlo, wdata, mf_req, err_clr,
    output mult_start, div_start, hi, lo, busy, stall, done, err_timeout, err_div0
  );

  modport slave (
    output op_mult, op_div, mult_done, mult_hi, mult_lo,
    output div_done, div_hi, div_lo, div_zero,
    output mthi, mtlo, wdata, mf_req, err_clr,
    input  mult_start, div_start, hi, lo, busy, stall, done, err_timeout, err_div0
  );
endinterface

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register owner and multiply/divide sequencer with a run watchdog.
// Define HILO_FORWARD_EN to forward a completing result onto hi/lo and release stall early.
module hilo_ctrl #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input logic         clock,
  input logic         reset,
  hilo_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             mult_start_q;
  logic             div_start_q;
  logic             done_q;
  logic             err_timeout_q;
  logic             err_div0_q;
  logic             expire;
  logic             busy;

  assign expire = (counter == CNT_W'(TIMEOUT_CYC - 1));
  assign busy   = (state != IDLE);

  // Sequencer; errors clear first so a same-cycle set takes priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      counter       <= '0;
      hi_q          <= '0;
      lo_q          <= '0;
      mult_start_q  <= 1'b0;
      div_start_q   <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      err_div0_q    <= 1'b0;
    end else begin
      mult_start_q <= 1'b0;
      div_start_q  <= 1'b0;
      done_q       <= 1'b0;
      if (bus.err_clr) begin
        err_timeout_q <= 1'b0;
        err_div0_q    <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (bus.op_mult) begin
            mult_start_q <= 1'b1;
            counter      <= '0;
            state        <= MULT;
          end else if (bus.op_div) begin
            div_start_q <= 1'b1;
            counter     <= '0;
            state       <= DIV;
          end
        end
        MULT: begin
          counter <= counter + CNT_W'(1);
          if (bus.mult_done) begin
            hi_q   <= bus.mult_hi;
            lo_q   <= bus.mult_lo;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (expire) begin
            err_timeout_q <= 1'b1;
            state         <= IDLE;
          end
        end
        DIV: begin
          counter <= counter + CNT_W'(1);
          if (bus.div_done) begin
            if (bus.div_zero) begin
              err_div0_q <= 1'b1;
            end else begin
              hi_q <= bus.div_hi;
              lo_q <= bus.div_lo;
            end
            done_q <= 1'b1;
            state  <= DONE;
          end else if (expire) begin
            err_timeout_q <= 1'b1;
            state         <= IDLE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HILO_FORWARD_EN
  logic mult_hit;
  logic div_hit;
  logic div_fwd;

  assign mult_hit = (state == MULT) && bus.mult_done;
  assign div_hit  = (state == DIV) && bus.div_done;
  assign div_fwd  = div_hit && !bus.div_zero;

  // A divide-by-zero completion leaves HI/LO untouched, so nothing is forwarded.
  assign bus.hi    = mult_hit ? bus.mult_hi : (div_fwd ? bus.div_hi : hi_q);
  assign bus.lo    = mult_hit ? bus.mult_lo : (div_fwd ? bus.div_lo : lo_q);
  assign bus.stall = bus.mf_req && busy && !(mult_hit || div_hit) && (state != DONE);
`else
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.stall = bus.mf_req && busy;
`endif

  assign bus.busy        = busy;
  assign bus.mult_start  = mult_start_q;
  assign bus.div_start   = div_start_q;
  assign bus.done        = done_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_div0    = err_div0_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed stimulus for hilo_ctrl, checked every cycle against a
// transaction-level model plus hand-computed literal expectations.
module tb_hilo_ctrl;
  localparam int unsigned W   = 32;
  localparam int unsigned TMO = 64;

  logic clock;
  logic reset;
  hilo_ctrl_if #(.WIDTH(W)) bus ();

  hilo_ctrl #(.WIDTH(W), .TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_err    = 0;
  int n_checks = 0;
  bit cmp_en   = 1'b0;

  int cnt_mstart = 0;
  int cnt_dstart = 0;
  int cnt_done   = 0;
  int cnt_busy   = 0;

  // Model: which unit is being waited on, how long, and whether the completion cycle follows.
  int         m_unit   = 0;
  bit         m_finish = 1'b0;
  int         m_waited = 0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  bit         m_mstart = 1'b0;
  bit         m_dstart = 1'b0;
  bit         m_done   = 1'b0;
  bit         m_errt   = 1'b0;
  bit         m_err0   = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_unit = 0; m_finish = 1'b0; m_waited = 0; m_hi = '0; m_lo = '0;
      m_mstart = 1'b0; m_dstart = 1'b0; m_done = 1'b0; m_errt = 1'b0; m_err0 = 1'b0;
    end else begin
      m_mstart = 1'b0; m_dstart = 1'b0; m_done = 1'b0;
      if (bus.err_clr) begin m_errt = 1'b0; m_err0 = 1'b0; end
      if (m_finish) begin
        m_finish = 1'b0;
      end else if (m_unit == 0) begin
        if (bus.mthi) m_hi = bus.wdata;
        if (bus.mtlo) m_lo = bus.wdata;
        if (bus.op_mult)     begin m_unit = 1; m_mstart = 1'b1; m_waited = 0; end
        else if (bus.op_div) begin m_unit = 2; m_dstart = 1'b1; m_waited = 0; end
      end else if ((m_unit == 1) ? bus.mult_done : bus.div_done) begin
        if (m_unit == 1) begin m_hi = bus.mult_hi; m_lo = bus.mult_lo; end
        else if (bus.div_zero) m_err0 = 1'b1;
        else begin m_hi = bus.div_hi; m_lo = bus.div_lo; end
        m_unit = 0; m_finish = 1'b1; m_done = 1'b1;
      end else if (m_waited + 1 == int'(TMO)) begin
        m_errt = 1'b1; m_unit = 0;
      end else begin
        m_waited = m_waited + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic compare_loop();
    bit hit;
    bit fwd;
    bit e_busy;
    bit e_stall;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
    forever begin
      @(negedge clock);
      #4;
      if (cmp_en) begin
        e_busy = (m_unit != 0) || m_finish;
        hit = (m_unit == 1 && bus.mult_done) || (m_unit == 2 && bus.div_done);
        fwd = hit && !(m_unit == 2 && bus.div_zero);
`ifdef HILO_FORWARD_EN
        e_hi    = fwd ? ((m_unit == 1) ? bus.mult_hi : bus.div_hi) : m_hi;
        e_lo    = fwd ? ((m_unit == 1) ? bus.mult_lo : bus.div_lo) : m_lo;
        e_stall = bus.mf_req && e_busy && !hit && !m_finish;
`else
        e_hi    = m_hi;
        e_lo    = m_lo;
        e_stall = bus.mf_req && e_busy;
        fwd     = fwd && 1'b0;
`endif
        chk("hi", 64'(bus.hi), 64'(e_hi));
        chk("lo", 64'(bus.lo), 64'(e_lo));
        chk("busy", 64'(bus.busy), 64'(e_busy));
        chk("stall", 64'(bus.stall), 64'(e_stall));
        chk("mult_start", 64'(bus.mult_start), 64'(m_mstart));
        chk("div_start", 64'(bus.div_start), 64'(m_dstart));
        chk("done", 64'(bus.done), 64'(m_done));
        chk("err_timeout", 64'(bus.err_timeout), 64'(m_errt));
        chk("err_div0", 64'(bus.err_div0), 64'(m_err0));
        if (bus.mult_start === 1'b1) cnt_mstart++;
        if (bus.div_start === 1'b1) cnt_dstart++;
        if (bus.done === 1'b1) cnt_done++;
        if (bus.busy === 1'b1) cnt_busy++;
      end
    end
  endtask

  task automatic clr();
    bus.op_mult = 1'b0; bus.op_div = 1'b0;
    bus.mult_done = 1'b0; bus.mult_hi = '0; bus.mult_lo = '0;
    bus.div_done = 1'b0; bus.div_hi = '0; bus.div_lo = '0; bus.div_zero = 1'b0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    bus.mf_req = 1'b0; bus.err_clr = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int s_ms, s_ds, s_done, s_busy;
    reset = 1'b1;
    clr();
    fork
      compare_loop();
    join_none
    step(2);
    cmp_en = 1'b1;
    #2;
    chk("rst_hi", 64'(bus.hi), 64'h0);
    chk("rst_lo", 64'(bus.lo), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_errs", {62'h0, bus.err_timeout, bus.err_div0}, 64'h0);
    reset = 1'b0;

    // Multiply completing after 33 cycles in MULT.
    step(1);
    s_ms = cnt_mstart; s_done = cnt_done; s_busy = cnt_busy;
    bus.op_mult = 1'b1; step(1); bus.op_mult = 1'b0;
    step(32);
    bus.mult_done = 1'b1; bus.mult_hi = 32'hFFFF_FFFF; bus.mult_lo = 32'hFFFF_FFEB;
    step(1); clr(); #2;
    chk("t1_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    chk("t1_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    chk("t1_done", 64'(bus.done), 64'h1);
    step(1);
    chk("t1_mstart_cnt", 64'(cnt_mstart - s_ms), 64'd1);
    chk("t1_done_cnt", 64'(cnt_done - s_done), 64'd1);
    chk("t1_busy_cnt", 64'(cnt_busy - s_busy), 64'd34);

    // MTHI then divide by zero; err_clr afterwards.
    bus.mthi = 1'b1; bus.wdata = 32'h1234; step(1); clr(); #2;
    chk("t2_mthi", 64'(bus.hi), 64'h1234);
    bus.op_div = 1'b1; step(1); bus.op_div = 1'b0;
    step(4);
    bus.div_done = 1'b1; bus.div_zero = 1'b1; bus.div_hi = 32'hAAAA; bus.div_lo = 32'hBBBB;
    step(1); clr(); #2;
    chk("t2_err_div0", 64'(bus.err_div0), 64'h1);
    chk("t2_hi", 64'(bus.hi), 64'h1234);
    chk("t2_lo", 64'(bus.lo), 64'hFFFF_FFEB);
    step(1); bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0; #2;
    chk("t2_err_clr", 64'(bus.err_div0), 64'h0);

    // Divide ignoring a stray multiplier done, then completing normally.
    step(1);
    bus.op_div = 1'b1; step(1); bus.op_div = 1'b0;
    bus.mult_done = 1'b1; bus.mult_hi = 32'hBAD; step(1); clr();
    step(2);
    bus.div_done = 1'b1; bus.div_hi = 32'd7; bus.div_lo = 32'h10;
    step(1); clr(); #2;
    chk("t2b_hi", 64'(bus.hi), 64'd7);
    chk("t2b_lo", 64'(bus.lo), 64'h10);
    step(1);

    // Divide that never completes: watchdog after 64 cycles in DIV.
    s_ds = cnt_dstart; s_done = cnt_done; s_busy = cnt_busy;
    bus.op_div = 1'b1; step(1); bus.op_div = 1'b0;
    step(69); #2;
    chk("t3_err_timeout", 64'(bus.err_timeout), 64'h1);
    chk("t3_busy", 64'(bus.busy), 64'h0);
    chk("t3_hi", 64'(bus.hi), 64'd7);
    chk("t3_done_cnt", 64'(cnt_done - s_done), 64'd0);
    chk("t3_busy_cnt", 64'(cnt_busy - s_busy), 64'd64);
    chk("t3_dstart_cnt", 64'(cnt_dstart - s_ds), 64'd1);
    bus.err_clr = 1'b1; step(1); bus.err_clr = 1'b0;

    // Reset mid-multiply; the late done lands in IDLE and is ignored.
    bus.op_mult = 1'b1; step(1); bus.op_mult = 1'b0;
    step(9); reset = 1'b1; step(1); reset = 1'b0;
    step(22);
    bus.mult_done = 1'b1; bus.mult_hi = 32'd5; bus.mult_lo = 32'd6;
    step(1); clr(); #2;
    chk("t4_hi", 64'(bus.hi), 64'h0);
    chk("t4_lo", 64'(bus.lo), 64'h0);
    chk("t4_busy", 64'(bus.busy), 64'h0);

    // MFHI/MFLO held across a multiply.
    step(1);
    bus.mf_req = 1'b1; bus.op_mult = 1'b1; step(1); bus.op_mult = 1'b0; #2;
    chk("t5_stall_run", 64'(bus.stall), 64'h1);
    step(3);
    bus.mult_done = 1'b1; bus.mult_hi = 32'hCAFE; bus.mult_lo = 32'hBEEF; #2;
`ifdef HILO_FORWARD_EN
    chk("t5_stall_hit", 64'(bus.stall), 64'h0);
    chk("t5_fwd_hi", 64'(bus.hi), 64'hCAFE);
    chk("t5_fwd_lo", 64'(bus.lo), 64'hBEEF);
`else
    chk("t5_stall_hit", 64'(bus.stall), 64'h1);
    chk("t5_reg_hi", 64'(bus.hi), 64'h0);
`endif
    step(1); bus.mult_done = 1'b0; #2;
`ifdef HILO_FORWARD_EN
    chk("t5_stall_done", 64'(bus.stall), 64'h0);
`else
    chk("t5_stall_done", 64'(bus.stall), 64'h1);
`endif
    chk("t5_hi", 64'(bus.hi), 64'hCAFE);
    step(1); #2;
    chk("t5_stall_idle", 64'(bus.stall), 64'h0);
    clr();

    // Simultaneous requests, MTHI alongside a start, writes and starts while busy.
    step(1);
    bus.op_mult = 1'b1; bus.op_div = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'h55;
    step(1); clr(); #2;
    chk("t6_mstart", 64'(bus.mult_start), 64'h1);
    chk("t6_dstart", 64'(bus.div_start), 64'h0);
    chk("t6_hi_written", 64'(bus.hi), 64'h55);
    bus.mthi = 1'b1; bus.wdata = 32'hDEAD; bus.op_div = 1'b1;
    step(1); clr(); #2;
    chk("t6_hi_busy", 64'(bus.hi), 64'h55);
    step(2);
    bus.mult_done = 1'b1; bus.mult_hi = 32'h11; bus.mult_lo = 32'h22;
    step(1); clr();
    bus.op_mult = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'h99;
    step(1); clr(); #2;
    chk("t6_hi_done", 64'(bus.hi), 64'h11);
    chk("t6_lo_done", 64'(bus.lo), 64'h22);
    chk("t6_op_in_done", 64'(bus.busy), 64'h0);
    bus.mult_done = 1'b1; bus.mult_hi = 32'hBAD;
    step(1); clr(); #2;
    chk("t6_idle_done", 64'(bus.hi), 64'h11);

    // Done arriving in the same cycle the watchdog expires.
    step(1);
    bus.op_mult = 1'b1; step(1); bus.op_mult = 1'b0;
    step(63);
    bus.mult_done = 1'b1; bus.mult_hi = 32'h1; bus.mult_lo = 32'h2;
    step(1); clr(); #2;
    chk("t7_done", 64'(bus.done), 64'h1);
    chk("t7_no_timeout", 64'(bus.err_timeout), 64'h0);
    chk("t7_hi", 64'(bus.hi), 64'h1);

    // Error set and err_clr in the same cycle.
    step(1);
    bus.op_div = 1'b1; step(1); bus.op_div = 1'b0;
    step(1);
    bus.div_done = 1'b1; bus.div_zero = 1'b1; bus.err_clr = 1'b1;
    step(1); clr(); #2;
    chk("t8_set_wins", 64'(bus.err_div0), 64'h1);
    step(1); bus.err_clr = 1'b1; step(1); clr(); #2;
    chk("t8_cleared", 64'(bus.err_div0), 64'h0);

    step(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
